// File: rtl/retire_rob.sv
// rtl/retire_rob.sv - 16-entry reorder buffer with 4-lane in-order retirement
//
// Purpose: entries are allocated in program order at tail and completed out of
// order by tag. Each cycle the contiguous run of completed entries at head
// (up to 4) retires onto registered, MSB-first packed lanes. Lane 0 is oldest.
//
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   flush                        (only with ROB_FLUSH_EN) discard all entries
//   alloc_valid/target_reg/writes_reg, alloc_ready, alloc_tag   allocate side
//   complete_valid/tag/data      execution result write-back
//   retirement_*_flat, instruction_writer_flat   registered retire lanes
//   count                        occupied entries, 0..16
//
// Build option: define ROB_FLUSH_EN to add the flush input.
module retire_rob (
  input  logic        clk,
  input  logic        rst_n,
`ifdef ROB_FLUSH_EN
  input  logic        flush,
`endif
  input  logic        alloc_valid,
  input  logic [3:0]  alloc_target_reg,
  input  logic        alloc_writes_reg,
  output logic        alloc_ready,
  output logic [3:0]  alloc_tag,
  input  logic        complete_valid,
  input  logic [3:0]  complete_tag,
  input  logic [15:0] complete_data,
  output logic [3:0]  retirement_write_data_enable_flat,
  output logic [15:0] retirement_target_reg_flat,
  output logic [63:0] retirement_write_data_flat,
  output logic [15:0] instruction_writer_flat,
  output logic [4:0]  count
);

  logic [15:0] ent_valid;
  logic [15:0] ent_done;
  logic [15:0] ent_writes;
  logic [3:0]  ent_target [16];
  logic [15:0] ent_data   [16];

  logic [3:0]  head;
  logic [3:0]  tail;
  logic        alloc_fire;
  logic        flush_now;

  logic [3:0]  lane_idx [4];
  logic [3:0]  lane_ok;
  logic [2:0]  n_ret;
  logic        run;

`ifdef ROB_FLUSH_EN
  assign flush_now = flush;
`else
  assign flush_now = 1'b0;
`endif

  // Registered count gates allocation, so a full ROB cannot accept an entry
  // in the same cycle that it retires.
  assign alloc_ready = (count != 5'd16);
  assign alloc_tag   = tail;
  assign alloc_fire  = alloc_valid && alloc_ready;

  // Retire run: stops at the first entry that is not valid && done. done is
  // registered, so a completion arriving this cycle cannot retire until next.
  always_comb begin
    lane_ok = '0;
    n_ret   = '0;
    run     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      lane_idx[i] = head + 4'(i);
      if (run && (5'(i) < count) && ent_valid[lane_idx[i]] && ent_done[lane_idx[i]]) begin
        lane_ok[i] = 1'b1;
        n_ret      = n_ret + 3'd1;
      end else begin
        run = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush_now) begin
      ent_valid <= '0;
      ent_done  <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      retirement_write_data_enable_flat <= '0;
      retirement_target_reg_flat        <= '0;
      retirement_write_data_flat        <= '0;
      instruction_writer_flat           <= '0;
    end else begin
      // Lane i occupies the i-th field counted from the MSB end.
      for (int i = 0; i < 4; i++) begin
        if (lane_ok[i]) begin
          retirement_write_data_enable_flat[3-i]       <= ent_writes[lane_idx[i]];
          retirement_target_reg_flat[(3-i)*4 +: 4]     <= ent_target[lane_idx[i]];
          retirement_write_data_flat[(3-i)*16 +: 16]   <= ent_data[lane_idx[i]];
          instruction_writer_flat[(3-i)*4 +: 4]        <= lane_idx[i];
          ent_valid[lane_idx[i]]                       <= 1'b0;
        end else begin
          retirement_write_data_enable_flat[3-i]       <= 1'b0;
          retirement_target_reg_flat[(3-i)*4 +: 4]     <= '0;
          retirement_write_data_flat[(3-i)*16 +: 16]   <= '0;
          instruction_writer_flat[(3-i)*4 +: 4]        <= '0;
        end
      end

      if (complete_valid && ent_valid[complete_tag]) begin
        ent_done[complete_tag] <= 1'b1;
        ent_data[complete_tag] <= complete_data;
      end

      // Placed after the completion update so allocation wins on a shared index.
      if (alloc_fire) begin
        ent_valid[tail]  <= 1'b1;
        ent_done[tail]   <= 1'b0;
        ent_writes[tail] <= alloc_writes_reg;
        ent_target[tail] <= alloc_target_reg;
        ent_data[tail]   <= '0;
      end

      head  <= head + {1'b0, n_ret};
      tail  <= tail + {3'b0, alloc_fire};
      count <= count + {4'b0, alloc_fire} - {2'b0, n_ret};
    end
  end

endmodule

// File: tb/tb_retire_rob.sv
// tb/tb_retire_rob.sv - self-checking bench for retire_rob
module tb_retire_rob;

  logic        clk = 1'b0;
  logic        rst_n;
`ifdef ROB_FLUSH_EN
  logic        flush = 1'b0;
`endif
  logic        alloc_valid, alloc_writes_reg, complete_valid;
  logic [3:0]  alloc_target_reg, complete_tag;
  logic [15:0] complete_data;
  logic        alloc_ready;
  logic [3:0]  alloc_tag;
  logic [3:0]  en_flat;
  logic [15:0] tgt_flat, wr_flat;
  logic [63:0] dat_flat;
  logic [4:0]  count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  retire_rob dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef ROB_FLUSH_EN
    .flush(flush),
`endif
    .alloc_valid(alloc_valid),
    .alloc_target_reg(alloc_target_reg),
    .alloc_writes_reg(alloc_writes_reg),
    .alloc_ready(alloc_ready),
    .alloc_tag(alloc_tag),
    .complete_valid(complete_valid),
    .complete_tag(complete_tag),
    .complete_data(complete_data),
    .retirement_write_data_enable_flat(en_flat),
    .retirement_target_reg_flat(tgt_flat),
    .retirement_write_data_flat(dat_flat),
    .instruction_writer_flat(wr_flat),
    .count(count)
  );

  typedef struct {
    logic        rn, av, aw, cv;
    logic [3:0]  at, ct;
    logic [15:0] cd;
    logic [4:0]  e_cnt;
    logic [3:0]  e_tag, e_en;
    logic [15:0] e_tgt, e_wr;
    logic [63:0] e_dat;
  } vec_t;

  typedef struct {
    logic [3:0]  tag, tgt;
    logic        done;
    logic [15:0] data;
  } sb_t;

  vec_t vt[$];
  sb_t  sb[$];

  function automatic vec_t mk(input logic rn, av, input logic [3:0] at, input logic aw, cv,
                              input logic [3:0] ct, input logic [15:0] cd, input logic [4:0] cnt,
                              input logic [3:0] tag, en, input logic [15:0] tgt, wr,
                              input logic [63:0] dat);
    vec_t v;
    v.rn = rn; v.av = av; v.at = at; v.aw = aw; v.cv = cv; v.ct = ct; v.cd = cd;
    v.e_cnt = cnt; v.e_tag = tag; v.e_en = en; v.e_tgt = tgt; v.e_wr = wr; v.e_dat = dat;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called at a falling edge; applies inputs across one rising edge and
  // returns at the next falling edge so outputs are sampled mid-cycle.
  task automatic drive(input logic rn, av, input logic [3:0] at, input logic aw, cv,
                       input logic [3:0] ct, input logic [15:0] cd);
    rst_n = rn; alloc_valid = av; alloc_target_reg = at; alloc_writes_reg = aw;
    complete_valid = cv; complete_tag = ct; complete_data = cd;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_out(input string nm, input logic [4:0] cnt, input logic [3:0] tag,
                         input logic [3:0] en, input logic [15:0] tgt, wr, input logic [63:0] dat);
    chk({nm, ".count"}, 64'(count), 64'(cnt));
    chk({nm, ".ready"}, 64'(alloc_ready), 64'(cnt != 5'd16));
    chk({nm, ".tag"},   64'(alloc_tag), 64'(tag));
    chk({nm, ".en"},    64'(en_flat), 64'(en));
    chk({nm, ".tgt"},   64'(tgt_flat), 64'(tgt));
    chk({nm, ".wr"},    64'(wr_flat), 64'(wr));
    chk({nm, ".dat"},   dat_flat, dat);
  endtask

  initial begin
    logic [3:0] exp_tail;
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk_out("reset", 0, 0, 0, 0, 0, 0);

    // Four allocations, completions in reverse order, all four retire together.
    vt.push_back(mk(1,1,1,1,0,0,0,         1,1,0,0,0,0));
    vt.push_back(mk(1,1,2,1,0,0,0,         2,2,0,0,0,0));
    vt.push_back(mk(1,1,3,1,0,0,0,         3,3,0,0,0,0));
    vt.push_back(mk(1,1,4,1,0,0,0,         4,4,0,0,0,0));
    vt.push_back(mk(1,0,0,0,1,3,16'h4444,  4,4,0,0,0,0));
    vt.push_back(mk(1,0,0,0,1,2,16'h3333,  4,4,0,0,0,0));
    vt.push_back(mk(1,0,0,0,1,1,16'h2222,  4,4,0,0,0,0));
    vt.push_back(mk(1,0,0,0,1,0,16'h1111,  4,4,0,0,0,0));
    vt.push_back(mk(1,0,0,0,0,0,0,         0,4,4'hF,16'h1234,16'h0123,64'h1111_2222_3333_4444));
    vt.push_back(mk(1,0,0,0,0,0,0,         0,4,0,0,0,0));
    // Reset with activity, then head entry completes last.
    vt.push_back(mk(0,1,5,1,1,0,16'h7777,  0,0,0,0,0,0));
    vt.push_back(mk(1,1,5,1,0,0,0,         1,1,0,0,0,0));
    vt.push_back(mk(1,1,6,1,0,0,0,         2,2,0,0,0,0));
    vt.push_back(mk(1,1,7,1,0,0,0,         3,3,0,0,0,0));
    vt.push_back(mk(1,0,0,0,1,1,16'hAAAA,  3,3,0,0,0,0));
    vt.push_back(mk(1,0,0,0,1,2,16'hBBBB,  3,3,0,0,0,0));
    vt.push_back(mk(1,0,0,0,0,0,0,         3,3,0,0,0,0));
    vt.push_back(mk(1,0,0,0,1,0,16'hCCCC,  3,3,0,0,0,0));
    vt.push_back(mk(1,0,0,0,0,0,0,         0,3,4'hE,16'h5670,16'h0120,64'hCCCC_AAAA_BBBB_0000));
    // Single retire concurrent with allocate; then non-writing entry at tag 5.
    vt.push_back(mk(1,1,9,1,0,0,0,         1,4,0,0,0,0));
    vt.push_back(mk(1,0,0,0,1,3,16'h3333,  1,4,0,0,0,0));
    vt.push_back(mk(1,1,1,1,0,0,0,         1,5,4'h8,16'h9000,16'h3000,64'h3333_0000_0000_0000));
    vt.push_back(mk(1,1,2,0,0,0,0,         2,6,0,0,0,0));
    vt.push_back(mk(1,1,3,1,0,0,0,         3,7,0,0,0,0));
    vt.push_back(mk(1,0,0,0,1,6,16'h6666,  3,7,0,0,0,0));
    vt.push_back(mk(1,0,0,0,1,5,16'h5555,  3,7,0,0,0,0));
    vt.push_back(mk(1,0,0,0,1,4,16'h4444,  3,7,0,0,0,0));
    vt.push_back(mk(1,0,0,0,0,0,0,         0,7,4'hA,16'h1230,16'h4560,64'h4444_5555_6666_0000));
    // Completion to unallocated tag, seven allocations, reset mid-stream.
    vt.push_back(mk(1,0,0,0,1,9,16'h9999,  0,7,0,0,0,0));
    for (int i = 0; i < 7; i++)
      vt.push_back(mk(1,1,4'(i+1),1,0,0,0, 5'(i+1),4'(i+8),0,0,0,0));
    vt.push_back(mk(0,1,1,1,1,7,16'hFFFF,  0,0,0,0,0,0));
    vt.push_back(mk(1,0,0,0,0,0,0,         0,0,0,0,0,0));

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].rn, vt[i].av, vt[i].at, vt[i].aw, vt[i].cv, vt[i].ct, vt[i].cd);
      chk_out($sformatf("vec%0d", i), vt[i].e_cnt, vt[i].e_tag, vt[i].e_en,
              vt[i].e_tgt, vt[i].e_wr, vt[i].e_dat);
    end

    // Full ROB: 17th allocation ignored, alloc during retire of a full ROB
    // ignored, then tags 0..3 are reused after wrap.
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("full.tag%0d", i), 64'(alloc_tag), 64'(i));
      drive(1, 1, 4'(i), 1, 0, 0, 0);
    end
    chk_out("full16", 16, 0, 0, 0, 0, 0);
    drive(1, 1, 4'hF, 1, 0, 0, 0);
    chk_out("full17", 16, 0, 0, 0, 0, 0);
    for (int i = 3; i >= 0; i--) drive(1, 0, 0, 0, 1, 4'(i), 16'h0A00 + 16'(i));
    drive(1, 1, 4'hF, 1, 0, 0, 0);
    chk_out("full_retire", 12, 0, 4'hF, 16'h0123, 16'h0123, 64'h0A00_0A01_0A02_0A03);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("wrap.tag%0d", i), 64'(alloc_tag), 64'(i));
      drive(1, 1, 4'(i), 1, 0, 0, 0);
    end
    chk_out("wrap", 16, 4, 0, 0, 0, 0);

`ifdef ROB_FLUSH_EN
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) drive(1, 1, 4'(i), 1, 0, 0, 0);
    for (int i = 3; i < 6; i++) drive(1, 0, 0, 0, 1, 4'(i), 16'h5000 + 16'(i));
    chk_out("pre_flush", 6, 6, 0, 0, 0, 0);
    flush = 1'b1;
    drive(1, 1, 4'h7, 1, 1, 0, 16'hDEAD);
    flush = 1'b0;
    chk_out("flush", 0, 0, 0, 0, 0, 0);
    drive(1, 1, 4'h2, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 1, 0, 16'h0042);
    drive(1, 0, 0, 0, 0, 0, 0);
    chk_out("post_flush", 0, 1, 4'h8, 16'h2000, 16'h0000, 64'h0042_0000_0000_0000);
`endif

    // Randomized phase against a scoreboard of in-flight entries.
    drive(0, 0, 0, 0, 0, 0, 0);
    exp_tail = 0;
    for (int c = 0; c < 600; c++) begin
      int          en_n;
      int          pend[$];
      logic        av, cv;
      logic [3:0]  atgt, ctag;
      logic [15:0] cdat;
      logic [3:0]  x_en;
      logic [15:0] x_tgt, x_wr;
      logic [63:0] x_dat;
      if (c >= 300 && sb.size() == 0) break;
      en_n = 0;
      for (int i = 0; i < sb.size() && i < 4; i++) begin
        if (sb[i].done) en_n++;
        else break;
      end
      av   = (c < 300) && (sb.size() < 16) && ($urandom % 3 != 0);
      atgt = 4'($urandom_range(1, 15));
      foreach (sb[j]) if (!sb[j].done) pend.push_back(j);
      cv   = (pend.size() > 0) && ((c >= 300) || ($urandom % 2 == 1));
      ctag = 0;
      cdat = 16'($urandom);
      if (cv) ctag = sb[pend[$urandom % pend.size()]].tag;
      drive(1, av, atgt, 1, cv, ctag, cdat);
      x_en = 0; x_tgt = 0; x_wr = 0; x_dat = 0;
      for (int i = 0; i < en_n; i++) begin
        x_en[3-i]             = 1'b1;
        x_tgt[(3-i)*4 +: 4]   = sb[i].tgt;
        x_wr[(3-i)*4 +: 4]    = sb[i].tag;
        x_dat[(3-i)*16 +: 16] = sb[i].data;
      end
      chk("rnd.en",  64'(en_flat), 64'(x_en));
      chk("rnd.tgt", 64'(tgt_flat), 64'(x_tgt));
      chk("rnd.wr",  64'(wr_flat), 64'(x_wr));
      chk("rnd.dat", dat_flat, x_dat);
      for (int i = 0; i < en_n; i++) void'(sb.pop_front());
      if (cv) foreach (sb[j]) if (sb[j].tag == ctag) begin
        sb[j].done = 1'b1;
        sb[j].data = cdat;
      end
      if (av) begin
        sb.push_back('{tag: exp_tail, tgt: atgt, done: 1'b0, data: 16'h0});
        exp_tail = exp_tail + 4'd1;
      end
      chk("rnd.count", 64'(count), 64'(sb.size()));
      chk("rnd.tag",   64'(alloc_tag), 64'(exp_tail));
    end
    chk("rnd.drain", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
